// File: rtl/cpu_run_controller_pkg.sv
// Shared types and constants for the CPU run controller and its bench.
package cpu_run_controller_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } run_state_t;

    localparam logic [31:0] DEFAULT_END_PC = 32'h0000_3ffc;

endpackage

// File: rtl/cpu_run_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear dominates enable.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the MIPS core: holds the CPU in reset, releases it, counts
// cycles/commits and stops the run on terminal PC, self-loop or cycle timeout.
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 10,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter logic [31:0] END_PC       = DEFAULT_END_PC,
    parameter int unsigned HALT_REPEAT  = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             commit,
    input  logic [31:0]      commit_pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      halt_pc,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);
    localparam logic [15:0] HOLD_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPEAT);

    run_state_t       state, state_nxt;
    logic [15:0]      hold_cnt, hold_cnt_nxt;
    logic [31:0]      prev_pc, prev_pc_nxt;
    logic             prev_vld, prev_vld_nxt;
    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
    logic [31:0]      halt_pc_nxt;
    logic             timeout_hit;

    // Widen both sides so a narrow CNT_W can never alias a large cycle budget.
    assign timeout_hit = (MAX_CYCLES != 0) &&
                         (64'(cycle_count) == (64'(MAX_CYCLES) - 64'd1));

    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        prev_pc_nxt  = prev_pc;
        prev_vld_nxt = prev_vld;
        rep_cnt_nxt  = rep_cnt;
        halt_pc_nxt  = halt_pc;

        unique case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = ST_RUN;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 16'd1;
                end
            end
            ST_RUN: begin
                if (commit) begin
                    prev_pc_nxt  = commit_pc;
                    prev_vld_nxt = 1'b1;
                    rep_cnt_nxt  = (prev_vld && (commit_pc == prev_pc)) ?
                                   rep_cnt + REP_W'(1) : REP_W'(1);
                end
                if (commit && (commit_pc == END_PC)) begin
                    state_nxt   = ST_HALTED;
                    halt_pc_nxt = commit_pc;
                end else if (commit && (rep_cnt_nxt == REP_HALT)) begin
                    state_nxt   = ST_HALTED;
                    halt_pc_nxt = commit_pc;
                end else if (timeout_hit) begin
                    state_nxt   = ST_TIMEOUT;
                    halt_pc_nxt = commit ? commit_pc : prev_pc;
                end
            end
            ST_HALTED, ST_TIMEOUT: begin
            end
            default: state_nxt = ST_HOLD;
        endcase

        if (restart) begin
            state_nxt    = ST_HOLD;
            hold_cnt_nxt = '0;
            prev_pc_nxt  = '0;
            prev_vld_nxt = 1'b0;
            rep_cnt_nxt  = '0;
            halt_pc_nxt  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            prev_pc   <= '0;
            prev_vld  <= 1'b0;
            rep_cnt   <= '0;
            halt_pc   <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            prev_pc   <= prev_pc_nxt;
            prev_vld  <= prev_vld_nxt;
            rep_cnt   <= rep_cnt_nxt;
            halt_pc   <= halt_pc_nxt;
            cpu_reset <= (state_nxt != ST_RUN);
            running   <= (state_nxt == ST_RUN);
            done      <= (state_nxt == ST_HALTED);
            timeout   <= (state_nxt == ST_TIMEOUT);
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (reset),
        .en  (state == ST_RUN),
        .clr (restart),
        .q   (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clk (clk),
        .rst (reset),
        .en  ((state == ST_RUN) && commit),
        .clr (restart),
        .q   (instr_count)
    );

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Parametrised, synthesizable run controller for the MIPS CPU top (`mips`), generalising the fixed "hold reset, then release" bench sequence.
- Drives the CPU's reset for a programmable number of cycles, then releases it.
- Counts cycles and committed instructions, and detects program end: terminal PC, self-loop halt, or cycle timeout.
- Sits between system clk/reset and the CPU; the bench or the board wrapper instantiates it alongside `mips`.

Parameters:
- RESET_CYCLES, 10: clk cycles cpu_reset stays high after controller reset releases or after restart; legal range 1..65535.
- MAX_CYCLES, 100000: run-cycle budget before timeout; 0 disables timeout.
- END_PC, 32'h0000_3ffc: PC value whose commit ends the run.
- HALT_REPEAT, 4: consecutive commits at the same PC that count as a self-loop halt; legal range ≥2.
- CNT_W, 32: width of the cycle and instruction counters.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high controller reset
- restart  input  1  one-cycle pulse; re-enters the reset hold from any state
- commit  input  1  CPU retired one instruction this cycle
- commit_pc  input  32  PC of the retired instruction, valid when commit=1
- cpu_reset  output  1  reset to the CPU (active-high, registered)
- running  output  1  high in state RUN
- done  output  1  high in HALTED; sticky until reset/restart
- timeout  output  1  high in TIMEOUT; sticky until reset/restart
- halt_pc  output  32  PC that ended the run
- cycle_count  output  CNT_W  clk cycles spent in RUN
- instr_count  output  CNT_W  commits accepted in RUN

Behaviour:
- Reset (async, active-high):
  - state=HOLD, hold counter=0, cpu_reset=1.
  - running=0, done=0, timeout=0, halt_pc=0, cycle_count=0, instr_count=0, repeat counter=0.
- HOLD:
  - cpu_reset=1; hold counter increments each clk.
  - When the counter reaches RESET_CYCLES-1, go to RUN on the next edge.
  - cpu_reset first reads 0 exactly RESET_CYCLES rising edges after reset deassertion.
  - commit is ignored.
- RUN:
  - cpu_reset=0, running=1, cycle_count +1 every clk.
  - On commit: instr_count +1.
    - If commit_pc equals the previous committed PC, repeat counter +1; otherwise repeat counter resets to 1.
  - Exit conditions, checked each clk, first match wins:
    1. commit && commit_pc==END_PC → HALTED, halt_pc=commit_pc.
    2. Repeat counter reaching HALT_REPEAT on this commit → HALTED, halt_pc=commit_pc.
    3. MAX_CYCLES≠0 and cycle_count==MAX_CYCLES-1 with no halt this cycle → TIMEOUT, halt_pc=last committed PC (0 if none).
  - A commit in the exit cycle is still counted in instr_count.
- HALTED / TIMEOUT:
  - Counters freeze; cpu_reset returns to 1 to stop the CPU.
  - done or timeout is held at 1; never both.
  - commit is ignored.
- restart (any state, synchronous): next state HOLD; counters, repeat counter, halt_pc, done and timeout clear; cpu_reset=1.
- Simultaneous events:
  - restart wins over any exit condition in the same cycle.
  - Async reset wins over everything.
- Counters saturate at all-ones; they never wrap.
- First commit in RUN has no previous PC: repeat counter=1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state enum (HOLD, RUN, HALTED, TIMEOUT) and the default END_PC constant, shared with the bench.
- One natural sub-module: sat_counter (parametrised width, enable, sync clear, saturating), instantiated for cycle_count and instr_count.

Test Plan:
- Reset timing: RESET_CYCLES=10, reset high 20 ns then low → cpu_reset falls exactly on the 10th rising edge after release; running rises the same edge.
- End PC: commits at PC 0x3000, 0x3004, 0x3008, then END_PC=0x300c → done=1, halt_pc=0x300c, instr_count=4, cpu_reset=1 next cycle.
- Self-loop halt: HALT_REPEAT=4, commits at 0x3010 ×4 → done on the 4th commit, halt_pc=0x3010. Pattern 0x3010,0x3010,0x3014,0x3010 → no halt.
- Timeout: MAX_CYCLES=50, commits never reach END_PC → timeout=1, done=0, cycle_count=50, counters frozen afterwards.
- Restart: restart pulsed while in RUN, and separately while in HALTED → counters=0, done=0, a new 10-cycle hold, then RUN. Restart coinciding with an END_PC commit → HOLD, done stays 0.
- Saturation and mid-run reset: CNT_W=4, 20 commits → instr_count holds 15. Async reset asserted mid-RUN → all outputs return to reset values immediately, without waiting for a clock edge.
